ram_pattern_writer: RTL and testbench
=====================================

Name: ram_pattern_writer

Overview:
- Autonomous write-side sequencer for the 32x3 dual-port RAM. The existing board logic only reads that RAM with a free-running counter; this block fills it instead.
- On a start pulse it writes a selectable pattern to every address through the RAM write port. It then reads every address back through the read port and checks the data.
- Reports busy, done and sticky error status for HEX/LEDR display in the board top level. It runs on the divided address clock.

Parameters:
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W = 32 words.
- DATA_W, 3, RAM word width.

Ports:
- addr_clk  input  1  block clock; the attached RAM port is clocked on the same edge.
- reset  input  1  synchronous, active-high.
- start  input  1  level sampled each edge; acted on only in IDLE or DONE.
- mode  input  2  pattern select, latched at start.
- seed  input  DATA_W  pattern seed, latched at start.
- wraddress  output  ADDR_W  RAM write address.
- wdata  output  DATA_W  RAM write data.
- wren  output  1  RAM write enable.
- rdaddress  output  ADDR_W  RAM read address.
- q  input  DATA_W  RAM read data; valid the cycle after rdaddress is sampled by the RAM (address registered, output unregistered).
- busy  output  1  high in FILL, VERIFY, FLUSH.
- done  output  1  high in DONE.
- error  output  1  sticky: at least one mismatch in the current run.
- err_addr  output  ADDR_W  address of the first mismatch.
- err_count  output  ADDR_W  mismatch count, saturating at 2**ADDR_W-1.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, wren=0, wraddress=0, wdata=0, rdaddress=0, busy=0, done=0, error=0, err_addr=0, err_count=0. Internal latched mode and seed are 0.
- Pattern for address a, truncated to DATA_W bits:
  - mode0: seed.
  - mode1: a+seed, mod 2**DATA_W.
  - mode2: a[DATA_W-1:0] XOR seed.
  - mode3: a[0] ? ~seed : seed.
- IDLE -> FILL when start=1.
  - That edge latches mode/seed and clears error/err_addr/err_count/done.
  - Same edge drives wren=1, wraddress=0, wdata=pattern(0).
- FILL: one write per cycle.
  - Each edge advances wraddress by 1 and wdata to pattern(new address).
  - At the edge leaving wraddress=DEPTH-1: wren=0, rdaddress=0, go VERIFY.
  - Duration: exactly DEPTH cycles with wren=1; no address is skipped or repeated.
- VERIFY: one read issued per cycle.
  - rdaddress increments each edge.
  - Expected value and address are delayed one cycle in a pipeline register.
  - The edge ending each cycle compares q with the value expected for the address issued the previous cycle.
  - After rdaddress=DEPTH-1 is issued, go FLUSH; rdaddress holds.
- FLUSH: one cycle; compares the last word, then go DONE.
- Mismatch handling:
  - error<=1.
  - err_count increments, saturating.
  - err_addr loads only on the first mismatch of the run.
- DONE: done=1, busy=0. Status holds until start=1 (behaves as from IDLE: done cleared, new run begins) or reset.
- Timing: start sampled at edge E0. FILL occupies the cycles after E0..E31, VERIFY after E32..E63, FLUSH after E64. done=1 is visible after E65.
- start while busy: ignored. Latched mode/seed are unchanged by input changes mid-run.
- Reset mid-run: next edge is IDLE, wren=0 immediately, status cleared. RAM contents are left partially written; the block does not care.
- wren is never high outside FILL. No write and read to the same address overlap, because the phases are disjoint.
- Wrap-around: address counters never wrap within a run. The FILL/VERIFY exit is decoded on the DEPTH-1 terminal value, not on overflow.

Test Plan:
- Reset, then start pulse with mode0, seed=3, ideal RAM model:
  - 32 consecutive cycles of wren=1, wraddress 0..31, wdata=3.
  - done rises at E65, error=0, err_count=0.
- mode1, seed=6: wdata sequence 6,7,0,1,...; wraddress=31 carries 5. Readback passes with error=0.
- mode2 run with the RAM model corrupting q at addresses 5 and 20:
  - error=1, err_addr=5, err_count=2.
  - A following clean start clears all three before the new run.
- start pulses at E10 of FILL and during VERIFY: no restart. Trace is identical to the uninterrupted run; done still at E65.
- Assert reset at cycle 40 (mid-VERIFY):
  - Next edge: busy=0, done=0, wren=0, all outputs at reset values.
  - A later start completes normally.
- RAM model corrupting every word in mode3: err_count saturates at 31, err_addr=0, done=1.

Source files
------------

// File: rtl/ram_pattern_writer_if.sv
// rtl/ram_pattern_writer_if.sv - write/read bus between the pattern writer and the 32x3 dual-port RAM
interface ram_pattern_writer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3
);
    logic [ADDR_W-1:0] wraddress;
    logic [DATA_W-1:0] wdata;
    logic              wren;
    logic [ADDR_W-1:0] rdaddress;
    logic [DATA_W-1:0] q;

    modport master (
        output wraddress,
        output wdata,
        output wren,
        output rdaddress,
        input  q
    );

    modport slave (
        input  wraddress,
        input  wdata,
        input  wren,
        input  rdaddress,
        output q
    );
endinterface

// File: rtl/ram_pattern_writer.sv
// rtl/ram_pattern_writer.sv - fills the dual-port RAM with a pattern, reads it back and checks it
module ram_pattern_writer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3
) (
    input  logic              addr_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    ram_pattern_writer_if.master ram,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] err_count
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        VERIFY,
        FLUSH,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    logic [1:0]        mode_r;
    logic [DATA_W-1:0] seed_r;
    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_exp;
    logic [ADDR_W-1:0] next_wr;
    logic              mismatch;

    // Only the low DATA_W address bits ever reach the pattern.
    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] s,
        input logic [DATA_W-1:0] a
    );
        case (m)
            2'd0:    pattern = s;
            2'd1:    pattern = a + s;
            2'd2:    pattern = a ^ s;
            default: pattern = a[0] ? ~s : s;
        endcase
    endfunction

    assign next_wr  = ram.wraddress + 1'b1;
    assign mismatch = pipe_valid && (ram.q != pipe_exp);

    always_ff @(posedge addr_clk) begin
        if (reset) begin
            state         <= IDLE;
            mode_r        <= '0;
            seed_r        <= '0;
            pipe_valid    <= 1'b0;
            pipe_addr     <= '0;
            pipe_exp      <= '0;
            ram.wren      <= 1'b0;
            ram.wraddress <= '0;
            ram.wdata     <= '0;
            ram.rdaddress <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_addr      <= '0;
            err_count     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= FILL;
                        mode_r        <= mode;
                        seed_r        <= seed;
                        error         <= 1'b0;
                        err_addr      <= '0;
                        err_count     <= '0;
                        done          <= 1'b0;
                        busy          <= 1'b1;
                        ram.wren      <= 1'b1;
                        ram.wraddress <= '0;
                        ram.wdata     <= pattern(mode, seed, '0);
                    end
                end
                FILL: begin
                    if (ram.wraddress == LAST) begin
                        ram.wren      <= 1'b0;
                        ram.rdaddress <= '0;
                        pipe_valid    <= 1'b0;
                        state         <= VERIFY;
                    end else begin
                        ram.wraddress <= next_wr;
                        ram.wdata     <= pattern(mode_r, seed_r, next_wr[DATA_W-1:0]);
                    end
                end
                VERIFY: begin
                    // The RAM registers rdaddress on this edge; its data is compared one edge later.
                    pipe_valid <= 1'b1;
                    pipe_addr  <= ram.rdaddress;
                    pipe_exp   <= pattern(mode_r, seed_r, ram.rdaddress[DATA_W-1:0]);
                    if (ram.rdaddress == LAST) begin
                        state <= FLUSH;
                    end else begin
                        ram.rdaddress <= ram.rdaddress + 1'b1;
                    end
                end
                FLUSH: begin
                    pipe_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if ((state == VERIFY || state == FLUSH) && mismatch) begin
                error <= 1'b1;
                if (err_count != LAST) begin
                    err_count <= err_count + 1'b1;
                end
                if (!error) begin
                    err_addr <= pipe_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_pattern_writer.sv
// tb/tb_ram_pattern_writer.sv - directed bench for ram_pattern_writer with a corruptible RAM model
module tb_ram_pattern_writer;

    logic       addr_clk;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [2:0] seed;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] err_addr;
    logic [4:0] err_count;

    int errors = 0;
    int checks = 0;

    logic [2:0] mem [32];
    logic       corrupt [32];
    logic [4:0] rd_reg;
    logic [2:0] wd_trace [32];
    int         dk;

    ram_pattern_writer_if #(.ADDR_W(5), .DATA_W(3)) rif ();

    ram_pattern_writer #(.ADDR_W(5), .DATA_W(3)) dut (
        .addr_clk  (addr_clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .ram       (rif),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    initial addr_clk = 1'b0;
    always #5 addr_clk = ~addr_clk;

    // Registered read address, unregistered data; a corrupted word has bit 0 flipped.
    always @(posedge addr_clk) begin
        if (rif.wren) mem[rif.wraddress] <= rif.wdata;
        rd_reg <= rif.rdaddress;
    end

    always_comb begin
        rif.q = mem[rd_reg] ^ {2'b00, corrupt[rd_reg]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_pat(input logic [1:0] m, input logic [2:0] s, input logic [4:0] a);
        case (m)
            2'd0:    exp_pat = s;
            2'd1:    exp_pat = a[2:0] + s;
            2'd2:    exp_pat = a[2:0] ^ s;
            default: exp_pat = a[0] ? ~s : s;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_err_addr"}, err_addr, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_wren"}, rif.wren, 0);
        check({tag, "_wraddress"}, rif.wraddress, 0);
        check({tag, "_wdata"}, rif.wdata, 0);
        check({tag, "_rdaddress"}, rif.rdaddress, 0);
    endtask

    // k counts edges after the start edge E0; outputs are sampled on the falling edge after Ek.
    task automatic run(input logic [1:0] m, input logic [2:0] s, input bit poke,
                       input bit mid_reset, output int done_k);
        int bad_wr;
        int wren_out;
        bad_wr   = 0;
        wren_out = 0;
        done_k   = -1;
        @(negedge addr_clk);
        start = 1'b1;
        mode  = m;
        seed  = s;
        @(negedge addr_clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_error", error, 0);
        check("start_err_addr", err_addr, 0);
        check("start_err_count", err_count, 0);
        for (int k = 0; k <= 80; k++) begin
            if (k > 0) @(negedge addr_clk);
            if (k < 32) begin
                wd_trace[k] = rif.wdata;
                if (rif.wren !== 1'b1 || rif.wraddress !== k[4:0] || rif.wdata !== exp_pat(m, s, k[4:0]))
                    bad_wr++;
            end else if (rif.wren !== 1'b0) begin
                wren_out++;
            end
            if (k == 64 && !mid_reset) check("flush_busy", busy, 1);
            if (poke) begin
                start = (k == 9 || k == 40);
                mode  = start ? ~m : m;
                seed  = start ? ~s : s;
            end
            if (mid_reset && k == 39) begin
                check("pre_reset_error", error, 1);
                reset = 1'b1;
            end
            if (mid_reset && k == 40) begin
                check_reset_values("mid_reset");
                reset = 1'b0;
                break;
            end
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        if (!mid_reset) begin
            check("fill_writes", bad_wr, 0);
            check("wren_outside_fill", wren_out, 0);
            check("done_busy", busy, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        seed  = 3'd0;
        for (int i = 0; i < 32; i++) corrupt[i] = 1'b0;
        repeat (2) @(negedge addr_clk);
        check_reset_values("reset");
        reset = 1'b0;

        run(2'd0, 3'd3, 1'b0, 1'b0, dk);
        check("m0_done_edge", dk, 65);
        check("m0_error", error, 0);
        check("m0_err_count", err_count, 0);
        check("m0_wdata0", wd_trace[0], 3);
        check("m0_wdata31", wd_trace[31], 3);

        run(2'd1, 3'd6, 1'b0, 1'b0, dk);
        check("m1_done_edge", dk, 65);
        check("m1_error", error, 0);
        check("m1_wdata0", wd_trace[0], 6);
        check("m1_wdata1", wd_trace[1], 7);
        check("m1_wdata2", wd_trace[2], 0);
        check("m1_wdata31", wd_trace[31], 5);

        corrupt[5]  = 1'b1;
        corrupt[20] = 1'b1;
        run(2'd2, 3'd5, 1'b0, 1'b0, dk);
        check("m2c_done_edge", dk, 65);
        check("m2c_error", error, 1);
        check("m2c_err_addr", err_addr, 5);
        check("m2c_err_count", err_count, 2);
        check("m2c_wdata3", wd_trace[3], 6);
        corrupt[5]  = 1'b0;
        corrupt[20] = 1'b0;

        run(2'd2, 3'd5, 1'b0, 1'b0, dk);
        check("m2_clean_error", error, 0);
        check("m2_clean_err_count", err_count, 0);

        run(2'd1, 3'd6, 1'b1, 1'b0, dk);
        check("poke_done_edge", dk, 65);
        check("poke_error", error, 0);
        check("poke_wdata31", wd_trace[31], 5);

        corrupt[5] = 1'b1;
        run(2'd3, 3'd2, 1'b0, 1'b1, dk);
        corrupt[5] = 1'b0;
        @(negedge addr_clk);
        check("after_reset_idle_busy", busy, 0);
        run(2'd0, 3'd1, 1'b0, 1'b0, dk);
        check("post_reset_done_edge", dk, 65);
        check("post_reset_error", error, 0);

        for (int i = 0; i < 32; i++) corrupt[i] = 1'b1;
        run(2'd3, 3'd4, 1'b0, 1'b0, dk);
        check("sat_done", done, 1);
        check("sat_error", error, 1);
        check("sat_err_count", err_count, 31);
        check("sat_err_addr", err_addr, 0);
        check("sat_wdata1", wd_trace[1], 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
